// File: rtl/spi_v3_components_pkg.sv
// spi_v3_components_pkg: shared buffer state encoding and source-index width helper
package spi_v3_components_pkg;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;
  function automatic int srcw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/spi_v3_components_rr_grant.sv
// spi_v3_components_rr_grant: one-hot round-robin grant, first eligible index from ptr upward with wrap
module spi_v3_components_rr_grant #(
  parameter int nreqs = 2,
  parameter int srcw  = 1
) (
  input  logic [nreqs-1:0] eligible,
  input  logic [srcw-1:0]  ptr,
  output logic [nreqs-1:0] grant
);
  always_comb begin
    int idx;
    grant = '0;
    idx = 0;
    for (int k = nreqs - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % nreqs;
      if (eligible[idx]) grant = {{(nreqs-1){1'b0}}, 1'b1} << idx;
    end
  end
endmodule

// File: rtl/spi_v3_components_rr_arbiter.sv
// spi_v3_components_rr_arbiter: round-robin arbiter feeding a one-entry output buffer
module spi_v3_components_rr_arbiter
  import spi_v3_components_pkg::*;
#(
  parameter  int nbits = 32,
  parameter  int nreqs = 2,
  localparam int srcw  = srcw_of(nreqs)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [nreqs-1:0]       en_mask,
  input  logic [nreqs-1:0]       recv_val,
  output logic [nreqs-1:0]       recv_rdy,
  input  logic [nreqs*nbits-1:0] recv_msg,
  output logic                   send_val,
  input  logic                   send_rdy,
  output logic [nbits-1:0]       send_msg,
  output logic [srcw-1:0]        send_src
);
  buf_state_t state;
  logic [nbits-1:0] data;
  logic [srcw-1:0] src, ptr, gidx;
  logic [nreqs-1:0] grant;
  logic full, accept_ok, accept;
  assign full      = state == FULL;
  assign accept_ok = !full || send_rdy;
  // gating with reset keeps every recv_rdy low while the buffer is held in reset
  assign recv_rdy  = (reset && accept_ok) ? grant : '0;
  assign accept    = |recv_rdy;
  assign send_val  = full;
  assign send_msg  = data;
  assign send_src  = src;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < nreqs; i++)
      if (grant[i]) gidx = srcw'(i);
  end
  spi_v3_components_rr_grant #(.nreqs(nreqs), .srcw(srcw)) u_grant (
    .eligible(recv_val & en_mask),
    .ptr     (ptr),
    .grant   (grant)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      data  <= '0;
      src   <= '0;
      ptr   <= '0;
    end else if (accept) begin
      state <= FULL;
      data  <= recv_msg[int'(gidx)*nbits +: nbits];
      src   <= gidx;
      ptr   <= (int'(gidx) == nreqs - 1) ? '0 : gidx + 1'b1;
    end else if (send_rdy) begin
      state <= EMPTY;
    end
  end
endmodule

// File: doc/spi_v3_components_rr_arbiter.md
SPI_V3_COMPONENTS_RR_ARBITER -- requirements
Module: spi_v3_components_rr_arbiter

Interface
REQ-001 Parameter nbits, default 32, width of every val/rdy message.
REQ-002 Parameter nreqs, default 2, number of requesters; legal range 2..8.
REQ-003 Derived localparam srcw = max(1, clog2(nreqs)), width of the source index.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-006 en_mask  input  nreqs  per-requester enable; bit i = 0 means requester i is never granted.
REQ-007 recv_val  input  nreqs  bit i = requester i presents a message.
REQ-008 recv_rdy  output  nreqs  bit i = arbiter accepts requester i this cycle.
REQ-009 recv_msg  input  nreqs*nbits  requester i message at bits [i*nbits +: nbits].
REQ-010 send_val  output  1  buffered message valid.
REQ-011 send_rdy  input  1  downstream (SPI minion adapter / loopback) ready.
REQ-012 send_msg  output  nbits  buffered message.
REQ-013 send_src  output  srcw  index of the requester that sourced send_msg.

Function
REQ-014 Block SHALL hold a one-entry output buffer: full flag, data register, source register; state EMPTY (full=0) or FULL (full=1).
REQ-015 send_val SHALL equal full; send_msg and send_src SHALL be driven directly from the buffer registers.
REQ-016 accept_ok SHALL be (!full) | send_rdy.
REQ-017 eligible[i] SHALL be recv_val[i] & en_mask[i].
REQ-018 Grant SHALL be one-hot or zero: the first eligible index scanning ptr, ptr+1, ..., wrapping modulo nreqs.
REQ-019 recv_rdy[i] SHALL be grant[i] & accept_ok; at most one recv_rdy bit high per cycle.
REQ-020 recv_rdy MAY depend combinationally on recv_val, en_mask and send_rdy; send_val SHALL NOT depend combinationally on any input.
REQ-021 On accept from requester i: data <= recv_msg slice i, src <= i, full <= 1, ptr <= (i+1) mod nreqs.
REQ-022 If full & send_rdy with no accept: full <= 0; data, src and ptr unchanged.
REQ-023 Drain and accept in the same cycle: full stays 1 with the new message; sustained throughput is one message per cycle.
REQ-024 Latency: message accepted at edge N SHALL appear on send_* in the cycle after edge N.
REQ-025 Transitions: EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on drain+accept or when send_rdy=0 (held stable).
REQ-026 While full & !send_rdy, send_msg/send_src SHALL be stable and all recv_rdy SHALL be 0.
REQ-027 ptr SHALL update only on accept; wrap from nreqs-1 to 0.
REQ-028 Clearing an en_mask bit SHALL NOT affect a message already buffered.
REQ-029 No eligible requester: grant zero, all recv_rdy 0, ptr unchanged.

Reset
REQ-030 reset=0 SHALL asynchronously force full=0, ptr=0, src=0, data=0.
REQ-031 During reset: send_val=0, send_msg=0, send_src=0, recv_rdy all 0.
REQ-032 Reset mid-transfer SHALL discard the buffered message; no message delivered twice after reset release.

Structure
REQ-033 Shared package spi_v3_components_pkg SHALL hold the EMPTY/FULL state encoding and the srcw/clog2 helper.
REQ-034 Grant logic SHALL be a sub-module spi_v3_components_rr_grant (inputs eligible, ptr; output one-hot grant), reusable by other SPI_v3 arbiters.
REQ-035 Only the output buffer and ptr SHALL be registers; no other state.

Verification (nreqs=2, nbits=32, en_mask=2'b11 unless stated)
REQ-036 Reset release, no requests -> send_val=0, recv_rdy=2'b00, send_msg=0.
REQ-037 recv_val=2'b11, msgs 0xAAAA0000/0xBBBB0001, send_rdy=1 held -> outputs alternate 0xAAAA0000 src0, 0xBBBB0001 src1, one per cycle.
REQ-038 Buffer holds 0x12345678 src1, send_rdy=0 for 3 cycles -> send_* stable, recv_rdy=2'b00; send_rdy=1 -> drained next edge.
REQ-039 en_mask=2'b01, recv_val=2'b11 -> only requester 0 accepted; requester 1 recv_rdy stays 0.
REQ-040 reset=0 asserted mid-cycle with buffer full (0xDEADBEEF) -> send_val drops immediately, ptr=0; after release, requester 0 wins first tie.
